conv2d_crop_norm: RTL

- Sink-side partner to conv2d.
- Consumes conv2d's raw 3x3 box-sum stream (2*width_p wide, one sum per input pixel).
- Discards sums whose window straddles the frame top or the line start (warm-up/border), divides kept sums by 9 and saturates to width_p.
- Emits a cropped, normalized pixel stream with start-of-frame, end-of-line and frame-done markers to the downstream display/capture logic.

---
 rtl/conv2d_pkg.sv | 15 +
 rtl/conv2d_div9.sv | 26 ++
 rtl/conv2d_crop_norm.sv | 98 +++++++++
 3 files changed

// File: rtl/conv2d_pkg.sv
// Shared types and constants for the conv2d sink-side crop/normalize path.
package conv2d_pkg;

  typedef enum logic {FILL, PASS} state_e;

  // floor(x/9) == (x*7282)>>16 exactly for x in 0..9*255.
  localparam int DIV9_MUL   = 7282;
  localparam int DIV9_SHIFT = 16;
  localparam int DIV9_MUL_W = 13;

  function automatic int sum_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/conv2d_div9.sv
// Combinational divide-by-9 of a 3x3 box sum, saturated to width_p bits.
module conv2d_div9
  import conv2d_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic [sum_width(width_p)-1:0] sum,
  output logic [width_p-1:0]            quotient
);

  localparam int SUM_W  = sum_width(width_p);
  localparam int PROD_W = SUM_W + DIV9_MUL_W;
  localparam logic [PROD_W-1:0] MAX_Q = PROD_W'((1 << width_p) - 1);

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] quo;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    prod     = PROD_W'(sum) * PROD_W'(DIV9_MUL);
    quo      = prod >> DIV9_SHIFT;
    quotient = quo[width_p-1:0];
    if (quo > MAX_Q) quotient = {width_p{1'b1}};
  end

endmodule

// File: rtl/conv2d_crop_norm.sv
// Crops warm-up/border sums from conv2d's box-sum stream and normalizes kept sums by 9.
module conv2d_crop_norm
  import conv2d_pkg::*;
#(
  parameter int linewidth_px_p = 16,
  parameter int lines_p        = 16,
  parameter int width_p        = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [sum_width(width_p)-1:0] data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [width_p-1:0]            data_o,
  output logic                          sof_o,
  output logic                          eol_o,
  output logic                          frame_done_o
);

  localparam int COL_W = $clog2(linewidth_px_p);
  localparam int ROW_W = $clog2(lines_p);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(linewidth_px_p - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(lines_p - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);
  localparam logic [ROW_W-1:0] ROW_FILL  = ROW_W'(1);

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  state_e             state, state_next;
  logic               accept, keep, xfer, col_wrap, row_wrap, last_q;
  logic [width_p-1:0] quotient;

  assign ready_o  = ~valid_o | ready_i;
  assign accept   = valid_i & ready_o;
  assign xfer     = valid_o & ready_i;
  assign col_wrap = (col == COL_LAST);
  assign row_wrap = col_wrap && (row == ROW_LAST);
  assign keep     = (state == PASS) && (col >= COL_FIRST);

  conv2d_div9 #(.width_p(width_p)) u_div9 (
    .sum      (data_i),
    .quotient (quotient)
  );

  always_comb begin
    state_next = state;
    if (accept && col_wrap) begin
      case (state)
        FILL:    if (row == ROW_FILL) state_next = PASS;
        PASS:    if (row == ROW_LAST) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= FILL;
    else         state <= state_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_wrap ? '0 : col + COL_W'(1);
      if (col_wrap) row <= row_wrap ? '0 : row + ROW_W'(1);
    end
  end

  // data_o/sof_o/eol_o are left as-is after a transfer; valid_o alone qualifies them.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o      <= 1'b0;
      data_o       <= '0;
      sof_o        <= 1'b0;
      eol_o        <= 1'b0;
      last_q       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= xfer & last_q;
      if (accept && keep) begin
        valid_o <= 1'b1;
        data_o  <= quotient;
        sof_o   <= (row == ROW_FIRST) && (col == COL_FIRST);
        eol_o   <= col_wrap;
        last_q  <= row_wrap;
      end else if (xfer) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
